// File: rtl/pipe_share_arbiter_pkg.sv
// Shared sizing, beat tag layout and arbiter state encoding for pipe_share_arbiter.
package pipe_arb_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int SRC_W       = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

    typedef struct packed {
        logic             last;
        logic [SRC_W-1:0] src;
    } beat_tag_t;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;
endpackage

// File: rtl/pipe_share_arbiter_if.sv
// Requester lanes, shared pipeline output and downstream credit return as one bundle.
interface pipe_share_arbiter_if import pipe_arb_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]             req_valid_i;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]             req_last_i;
    logic [NUM_REQ-1:0]             req_ready_o;
    logic                           credit_return_i;
    logic                           out_valid_o;
    logic [DATA_W-1:0]              out_data_o;
    logic                           out_last_o;
    logic [SRC_W-1:0]               out_src_o;
    logic                           busy_o;
    logic                           credit_err_o;

    modport master (
        output req_valid_i, req_data_i, req_last_i, credit_return_i,
        input  req_ready_o, out_valid_o, out_data_o, out_last_o, out_src_o, busy_o, credit_err_o
    );

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, credit_return_i,
        output req_ready_o, out_valid_o, out_data_o, out_last_o, out_src_o, busy_o, credit_err_o
    );
endinterface

// File: rtl/pipe_share_arbiter_data_pipeline.sv
// Fixed-latency delay line: DEPTH register stages, or a plain wire when DEPTH is 0.
module data_pipeline #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 2,
    parameter bit               RESET_EN    = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    generate
        if (DEPTH == 0) begin : g_comb
            assign q = d;
        end else begin : g_regs
            logic [WIDTH-1:0] stage [DEPTH];

            // Data-only instances skip the reset so the stages stay plain flops.
            always_ff @(posedge clk) begin
                if (RESET_EN && rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VALUE;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/pipe_share_arbiter.sv
// Round-robin arbiter with packet lock sharing one non-stallable pipeline;
// issue is gated by downstream buffer credits since beats cannot be held once issued.
module pipe_share_arbiter import pipe_arb_pkg::*; #(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PIPE_DEPTH = 2,
    parameter int CREDITS    = 8
) (
    input logic                 clk,
    input logic                 rst,
    pipe_share_arbiter_if.slave bus
);
    localparam int CW    = $clog2(CREDITS + 1);
    localparam int IW    = $clog2(PIPE_DEPTH + 2);
    localparam int TAG_W = $bits(beat_tag_t) + 1;
    localparam logic [0:0] ST_IDLE   = ARB_IDLE;
    localparam logic [0:0] ST_LOCKED = ARB_LOCKED;

    logic [0:0]        state;
    logic [SRC_W-1:0]  grant_idx, rr_ptr, win_idx, acc_idx;
    logic [CW-1:0]     credit_cnt;
    logic [IW-1:0]     inflight;
    logic              credit_err, win_found, has_credit, accept, acc_last;
    logic [NUM_REQ-1:0] ready;
    logic [DATA_W-1:0] acc_data;
    beat_tag_t         tag_in, tag_out;
    logic [TAG_W-1:0]  tag_pipe_out;

    // Rotate so the slot after ptr sits at bit 0, take the lowest set bit, rotate back.
    function automatic void rr_pick(input  logic [NUM_REQ-1:0] valid,
                                    input  logic [SRC_W-1:0]   ptr,
                                    output logic               found,
                                    output logic [SRC_W-1:0]   idx);
        logic [2*NUM_REQ-1:0] dbl;
        int start;
        start = (int'(ptr) + 1) % NUM_REQ;
        dbl   = {valid, valid} >> start;
        found = 1'b0;
        idx   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (dbl[j]) begin
                found = 1'b1;
                idx   = SRC_W'((start + j) % NUM_REQ);
            end
        end
    endfunction

    always_comb begin
        has_credit = (credit_cnt != '0);
        rr_pick(bus.req_valid_i, rr_ptr, win_found, win_idx);
        ready   = '0;
        acc_idx = (state == ST_LOCKED) ? grant_idx : win_idx;
        if (!rst) begin
            if (state == ST_LOCKED) ready[grant_idx] = has_credit;
            else if (win_found)     ready[win_idx]   = has_credit;
        end
        accept   = |(ready & bus.req_valid_i);
        acc_last = bus.req_last_i[acc_idx];
        acc_data = bus.req_data_i[acc_idx];
        tag_in   = '{last: acc_last, src: acc_idx};
    end

    assign bus.req_ready_o = ready;

    data_pipeline #(.WIDTH(TAG_W), .DEPTH(PIPE_DEPTH), .RESET_EN(1'b1), .RESET_VALUE('0)) u_tag_pipe (
        .clk(clk), .rst(rst), .d({accept, tag_in}), .q(tag_pipe_out)
    );

    data_pipeline #(.WIDTH(DATA_W), .DEPTH(PIPE_DEPTH), .RESET_EN(1'b0), .RESET_VALUE('0)) u_data_pipe (
        .clk(clk), .rst(rst), .d(acc_data), .q(bus.out_data_o)
    );

    assign {bus.out_valid_o, tag_out} = tag_pipe_out;
    assign bus.out_last_o   = tag_out.last;
    assign bus.out_src_o    = tag_out.src;
    assign bus.busy_o       = (state == ST_LOCKED) || (inflight != '0);
    assign bus.credit_err_o = credit_err;

    // A simultaneous accept and return cancel; a return into a full counter is only flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant_idx  <= '0;
            rr_ptr     <= SRC_W'(NUM_REQ - 1);
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
            inflight   <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= acc_idx;
                if (state == ST_IDLE && !acc_last) begin
                    state     <= ST_LOCKED;
                    grant_idx <= acc_idx;
                end else if (state == ST_LOCKED && acc_last) begin
                    state <= ST_IDLE;
                end
            end
            if (accept && !bus.credit_return_i) begin
                credit_cnt <= credit_cnt - CW'(1);
            end else if (bus.credit_return_i && !accept) begin
                if (credit_cnt == CW'(CREDITS)) credit_err <= 1'b1;
                else                            credit_cnt <= credit_cnt + CW'(1);
            end
            inflight <= inflight + IW'(accept) - IW'(bus.out_valid_o);
        end
    end
endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Directed scenarios plus randomized traffic for pipe_share_arbiter, checked every
// cycle against a behavioural model of grants, credits and the delayed output stream.
module tb_pipe_share_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_W     = 8;
    localparam int SRC_W      = 2;
    localparam int PIPE_DEPTH = 2;
    localparam int CREDITS    = 2;

    typedef struct packed {
        logic              valid;
        logic              last;
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] data;
    } exp_beat_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   auto_ret = 1'b0;

    // Model state: free credits, locked owner (-1 = none), last granted index, sticky error
    int        m_credit, m_owner, m_ptr;
    bit        m_err;
    exp_beat_t hist[$];

    pipe_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    pipe_share_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PIPE_DEPTH(PIPE_DEPTH), .CREDITS(CREDITS)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_credit = CREDITS;
        m_owner  = -1;
        m_ptr    = NUM_REQ - 1;
        m_err    = 1'b0;
        hist.delete();
    endtask

    // Grant rule: locked owner gets ready whenever credit exists, otherwise the first
    // valid requester searching upward from the last winner.
    function automatic logic [NUM_REQ-1:0] model_ready();
        logic [NUM_REQ-1:0] r;
        bit found;
        r = '0;
        found = 1'b0;
        if (rst || m_credit == 0) return r;
        if (m_owner >= 0) begin
            r[m_owner] = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int i;
                i = (m_ptr + k) % NUM_REQ;
                if (!found && bus.req_valid_i[i]) begin
                    r[i]  = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic drive(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] l, input logic ret);
        bus.req_valid_i     = v;
        bus.req_last_i      = l;
        bus.credit_return_i = ret;
        for (int i = 0; i < NUM_REQ; i++) bus.req_data_i[i] = DATA_W'($urandom);
    endtask

    // One clock cycle: compare all outputs against the model, then advance the model.
    task automatic tick();
        logic [NUM_REQ-1:0] er;
        exp_beat_t eo, nb;
        logic eb, ret;
        int acc;
        if (auto_ret) bus.credit_return_i = (m_credit < CREDITS);
        #1;
        ret = bus.credit_return_i;
        er  = model_ready();
        checks++;
        if (bus.req_ready_o !== er) begin
            failures++;
            $display("[TB] FAIL ready cycle=%0d got=%b expected=%b", cyc, bus.req_ready_o, er);
        end
        eo = '0;
        if (hist.size() >= PIPE_DEPTH) eo = hist[hist.size() - PIPE_DEPTH];
        checks++;
        if (bus.out_valid_o !== eo.valid) begin
            failures++;
            $display("[TB] FAIL out_valid cycle=%0d got=%b expected=%b", cyc, bus.out_valid_o, eo.valid);
        end
        if (eo.valid) begin
            checks++;
            if ({bus.out_last_o, bus.out_src_o, bus.out_data_o} !== {eo.last, eo.src, eo.data}) begin
                failures++;
                $display("[TB] FAIL out_beat cycle=%0d got last=%b src=%0d data=%h expected last=%b src=%0d data=%h",
                         cyc, bus.out_last_o, bus.out_src_o, bus.out_data_o, eo.last, eo.src, eo.data);
            end
        end
        eb = (m_owner >= 0);
        for (int k = 1; k <= PIPE_DEPTH; k++)
            if (hist.size() >= k && hist[hist.size() - k].valid) eb = 1'b1;
        checks++;
        if (bus.busy_o !== eb) begin
            failures++;
            $display("[TB] FAIL busy cycle=%0d got=%b expected=%b", cyc, bus.busy_o, eb);
        end
        checks++;
        if (bus.credit_err_o !== m_err) begin
            failures++;
            $display("[TB] FAIL credit_err cycle=%0d got=%b expected=%b", cyc, bus.credit_err_o, m_err);
        end

        acc = -1;
        for (int i = 0; i < NUM_REQ; i++) if (er[i] && bus.req_valid_i[i]) acc = i;
        nb = '0;
        if (acc >= 0) nb = '{1'b1, bus.req_last_i[acc], SRC_W'(acc), bus.req_data_i[acc]};
        if (rst) begin
            model_reset();
        end else begin
            hist.push_back(nb);
            if (hist.size() > 8) hist.delete(0);
            if (acc >= 0) begin
                m_ptr = acc;
                if (m_owner >= 0) begin
                    if (nb.last) m_owner = -1;
                end else if (!nb.last) begin
                    m_owner = acc;
                end
            end
            if (acc >= 0 && !ret) m_credit--;
            else if (ret && acc < 0) begin
                if (m_credit == CREDITS) m_err = 1'b1;
                else                     m_credit++;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive('1, '1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({bus.req_ready_o, bus.out_valid_o, bus.out_last_o, bus.busy_o, bus.credit_err_o} !== 8'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got ready=%b valid=%b last=%b busy=%b err=%b expected all 0",
                     bus.req_ready_o, bus.out_valid_o, bus.out_last_o, bus.busy_o, bus.credit_err_o);
        end
        model_reset();
        tick();
        rst = 1'b0;
        drive('0, '0, 1'b0);
        tick();
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp;
        auto_ret = 1'b1;
        for (int n = 0; n < 5; n++) begin
            drive('1, '1, 1'b0);
            #1;
            exp = 4'b0001 << (n % NUM_REQ);
            checks++;
            if (bus.req_ready_o !== exp) begin
                failures++;
                $display("[TB] FAIL rr_grant step=%0d got=%b expected=%b", n, bus.req_ready_o, exp);
            end
            tick();
        end
        drive('0, '0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_packet_lock();
        logic [NUM_REQ-1:0] exp_seq [5];
        logic [NUM_REQ-1:0] v_seq [5];
        logic [NUM_REQ-1:0] l_seq [5];
        auto_ret = 1'b1;
        drive(4'b0010, 4'b0000, 1'b0);
        tick();
        // Bubble at beat 2, beats 2..4, then req2 once the lock releases
        v_seq   = '{4'b0100, 4'b0110, 4'b0110, 4'b0110, 4'b0100};
        l_seq   = '{4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0100};
        exp_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        for (int n = 0; n < 5; n++) begin
            drive(v_seq[n], l_seq[n], 1'b0);
            #1;
            checks++;
            if (bus.req_ready_o !== exp_seq[n]) begin
                failures++;
                $display("[TB] FAIL lock_hold step=%0d got=%b expected=%b", n, bus.req_ready_o, exp_seq[n]);
            end
            tick();
        end
        drive('0, '0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_credit_block();
        logic [NUM_REQ-1:0] l_seq [10];
        logic               r_seq [10];
        logic [NUM_REQ-1:0] exp_seq [10];
        auto_ret = 1'b0;
        // 3-beat packet stalls after two beats, one return frees beat 3,
        // then return-at-zero and accept-plus-return cases on single-beat packets
        l_seq   = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                    4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        r_seq   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_seq = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
                    4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
        for (int n = 0; n < 10; n++) begin
            drive(4'b0001, l_seq[n], r_seq[n]);
            #1;
            checks++;
            if (bus.req_ready_o !== exp_seq[n]) begin
                failures++;
                $display("[TB] FAIL credit_gate step=%0d got=%b expected=%b", n, bus.req_ready_o, exp_seq[n]);
            end
            if (n == 2) begin
                checks++;
                if (bus.busy_o !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL credit_lock_busy got=%b expected=1", bus.busy_o);
                end
            end
            tick();
        end
        auto_ret = 1'b1;
        drive('0, '0, 1'b0);
        repeat (4) tick();
    endtask

    task automatic test_credit_overflow();
        logic [NUM_REQ-1:0] exp_seq [3];
        auto_ret = 1'b0;
        drive('0, '0, 1'b1);
        tick();
        exp_seq = '{4'b0001, 4'b0001, 4'b0000};
        for (int n = 0; n < 3; n++) begin
            drive(4'b0001, 4'b0001, 1'b0);
            #1;
            checks++;
            if ({bus.credit_err_o, bus.req_ready_o} !== {1'b1, exp_seq[n]}) begin
                failures++;
                $display("[TB] FAIL credit_overflow step=%0d got err=%b ready=%b expected err=1 ready=%b",
                         n, bus.credit_err_o, bus.req_ready_o, exp_seq[n]);
            end
            tick();
        end
        auto_ret = 1'b1;
        drive('0, '0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_packet();
        auto_ret = 1'b0;
        drive(4'b0010, 4'b0000, 1'b0);
        tick();
        drive(4'b0010, 4'b0000, 1'b0);
        tick();
        rst = 1'b1;
        drive('1, '1, 1'b0);
        tick();
        rst = 1'b0;
        drive('1, '1, 1'b0);
        #1;
        checks++;
        if ({bus.out_valid_o, bus.busy_o, bus.credit_err_o, bus.req_ready_o} !== 7'b000_0001) begin
            failures++;
            $display("[TB] FAIL reset_mid_packet got valid=%b busy=%b err=%b ready=%b expected 0 0 0 0001",
                     bus.out_valid_o, bus.busy_o, bus.credit_err_o, bus.req_ready_o);
        end
        tick();
        auto_ret = 1'b1;
        drive('0, '0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_random();
        auto_ret = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_valid_i[i] = ($urandom_range(0, 9) < 7);
                bus.req_last_i[i]  = ($urandom_range(0, 3) == 0);
                bus.req_data_i[i]  = DATA_W'($urandom);
            end
            if (m_credit < CREDITS) bus.credit_return_i = ($urandom_range(0, 2) == 0);
            else                    bus.credit_return_i = ($urandom_range(0, 39) == 0);
            tick();
        end
        rst = 1'b0;
        auto_ret = 1'b1;
        drive('0, '0, 1'b0);
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1;
        drive('0, '0, 1'b0);
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_credit_block();
        test_credit_overflow();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
